// File: rtl/parking_gate_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : parking_gate_if
// Purpose  : Sensor/request inputs and gate/status outputs of one entrance.
// Revision : 1.0
// ============================================================================
interface parking_gate_if #(
    parameter int CNT_W = 4
);
    logic             entry_req;
    logic             enter;
    logic             exit;
    logic             gate_open;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             denied;
    logic             timeout;
    logic             err;

    // Master drives the sensor/button side and observes the controller.
    modport master (
        output entry_req, enter, exit,
        input  gate_open, count, full, empty, denied, timeout, err
    );

    modport slave (
        input  entry_req, enter, exit,
        output gate_open, count, full, empty, denied, timeout, err
    );
endinterface
`default_nettype wire

// File: rtl/parking_gate_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : parking_gate_controller
// Purpose  : Occupancy counter and entry-gate FSM for one parking entrance.
// Revision : 1.0
// ============================================================================
module parking_gate_controller #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 1000,
    parameter int TMR_W    = 10
) (
    input  wire logic     clk,
    input  wire logic     reset,
    parking_gate_if.slave bus
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_OPEN     = 2'd1;
    localparam logic [1:0]       c_HOLD     = 2'd2;
    localparam logic [CNT_W-1:0] c_CAP      = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Occupancy counter
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_count;
    logic             r_err;
    logic [CNT_W-1:0] w_count_next;
    logic             w_enter_ok;
    logic             w_exit_ok;
    logic             w_err_next;
    logic             w_full;
    logic             w_empty;

    // Simultaneous accepted enter and exit cancel; a rejected pulse never
    // moves the count, so it can neither wrap nor exceed CAPACITY.
    always_comb begin
        w_enter_ok   = bus.enter && (r_count < c_CAP);
        w_exit_ok    = bus.exit  && (r_count != '0);
        w_err_next   = (bus.enter && !w_enter_ok) || (bus.exit && !w_exit_ok);
        w_count_next = r_count;
        if (w_enter_ok && !w_exit_ok) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_exit_ok && !w_enter_ok) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_err   <= w_err_next;
        end
    end

    assign w_full  = (r_count == c_CAP);
    assign w_empty = (r_count == '0);

    // ------------------------------------------------------------------------
    // Gate FSM: state register
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_denied;
    logic             r_timeout;
    logic [1:0]       w_state_next;
    logic [TMR_W-1:0] w_timer_next;
    logic             w_denied_next;
    logic             w_timeout_next;
    logic             w_gate_open;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_timer   <= '0;
            r_denied  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_denied  <= w_denied_next;
            r_timeout <= w_timeout_next;
        end
    end

    // ------------------------------------------------------------------------
    // Gate FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_denied_next  = 1'b0;
        w_timeout_next = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.entry_req) begin
                    if (!w_full) begin
                        w_state_next = c_OPEN;
                        w_timer_next = '0;
                    end else begin
                        w_state_next  = c_HOLD;
                        w_denied_next = 1'b1;
                    end
                end
            end
            c_OPEN: begin
                // A car arriving on the last open cycle beats the timeout.
                if (bus.enter) begin
                    w_state_next = c_HOLD;
                end else if (r_timer == c_TMR_LAST) begin
                    w_state_next   = c_HOLD;
                    w_timeout_next = 1'b1;
                end else begin
                    w_timer_next = r_timer + TMR_W'(1);
                end
            end
            c_HOLD: begin
                if (!bus.entry_req) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Gate FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_gate_open = (r_state == c_OPEN);
    end

    assign bus.gate_open = w_gate_open;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.denied    = r_denied;
    assign bus.timeout   = r_timeout;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_parking_gate_controller
// Purpose  : Vector table plus directed sequences for parking_gate_controller.
// Revision : 1.0
// ============================================================================
module tb_parking_gate_controller;

    typedef struct packed {
        logic       req;
        logic       en;
        logic       ex;
        logic       g;
        logic [3:0] c;
        logic       d;
        logic       t;
        logic       e;
    } vec_t;

    localparam int c_NTBL = 20;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    vec_t sb[$];
    vec_t tbl [0:c_NTBL-1];

    parking_gate_if #(.CNT_W(4)) bus ();

    parking_gate_controller #(
        .CAPACITY (8),
        .CNT_W    (4),
        .TIMEOUT  (1000),
        .TMR_W    (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    function automatic vec_t mk(input logic req, input logic en, input logic ex,
                                input logic g, input int c, input logic d,
                                input logic t, input logic e);
        vec_t v;
        v.req = req; v.en = en; v.ex = ex;
        v.g = g; v.c = 4'(c); v.d = d; v.t = t; v.e = e;
        return v;
    endfunction

    task automatic check_now(input string name, input vec_t exp);
        logic [9:0] act;
        logic [9:0] want;
        act  = {bus.gate_open, bus.count, bus.full, bus.empty,
                bus.denied, bus.timeout, bus.err};
        want = {exp.g, exp.c, (exp.c == 4'd8), (exp.c == 4'd0), exp.d, exp.t, exp.e};
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: {gate,count,full,empty,denied,timeout,err} got %b required %b",
                     name, act, want);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input string name, input vec_t v);
        @(negedge clk);
        bus.entry_req = v.req;
        bus.enter     = v.en;
        bus.exit      = v.ex;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got 0 entries required 1", name);
        end else begin
            check_now(name, sb.pop_front());
        end
    endtask

    initial begin
        int gate_cycles;
        int tmo_pulses;

        n_cmp = 0;
        n_bad = 0;
        bus.entry_req = 1'b0;
        bus.enter     = 1'b0;
        bus.exit      = 1'b0;

        // Basic request/enter, cancellation, errors, exits while open.
        tbl[0]  = mk(1,0,0, 1,0,0,0,0);
        tbl[1]  = mk(1,0,0, 1,0,0,0,0);
        tbl[2]  = mk(1,0,0, 1,0,0,0,0);
        tbl[3]  = mk(0,0,0, 1,0,0,0,0);
        tbl[4]  = mk(0,1,0, 0,1,0,0,0);
        tbl[5]  = mk(0,0,0, 0,1,0,0,0);
        tbl[6]  = mk(0,1,0, 0,2,0,0,0);
        tbl[7]  = mk(0,1,0, 0,3,0,0,0);
        tbl[8]  = mk(0,1,1, 0,3,0,0,0);
        tbl[9]  = mk(0,0,1, 0,2,0,0,0);
        tbl[10] = mk(0,0,1, 0,1,0,0,0);
        tbl[11] = mk(0,0,1, 0,0,0,0,0);
        tbl[12] = mk(0,0,1, 0,0,0,0,1);
        tbl[13] = mk(0,0,0, 0,0,0,0,0);
        tbl[14] = mk(0,1,0, 0,1,0,0,0);
        tbl[15] = mk(1,0,0, 1,1,0,0,0);
        tbl[16] = mk(0,0,1, 1,0,0,0,0);
        tbl[17] = mk(0,0,1, 1,0,0,0,1);
        tbl[18] = mk(0,1,0, 0,1,0,0,0);
        tbl[19] = mk(0,0,0, 0,1,0,0,0);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_now("reset_state", mk(0,0,0, 0,0,0,0,0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < c_NTBL; i++) begin
            step($sformatf("table[%0d]", i), tbl[i]);
        end

        // Fill to capacity from count 1 with full request/enter/release cycles.
        for (int k = 1; k < 8; k++) begin
            step("fill_req",   mk(1,0,0, 1,k,  0,0,0));
            step("fill_enter", mk(1,1,0, 0,k+1,0,0,0));
            step("fill_rel",   mk(0,0,0, 0,k+1,0,0,0));
        end
        step("full_deny",      mk(1,0,0, 0,8,1,0,0));
        step("full_deny_hold", mk(1,0,0, 0,8,0,0,0));
        step("full_release",   mk(0,0,0, 0,8,0,0,0));
        step("full_enter_err", mk(0,1,0, 0,8,0,0,1));
        step("full_enter_exit",mk(0,1,1, 0,7,0,0,1));
        step("after_err",      mk(0,0,0, 0,7,0,0,0));
        step("reopen_req",     mk(1,0,0, 1,7,0,0,0));
        step("reopen_enter",   mk(0,1,0, 0,8,0,0,0));
        step("reopen_idle",    mk(0,0,0, 0,8,0,0,0));
        step("exit_7",         mk(0,0,1, 0,7,0,0,0));
        step("exit_6",         mk(0,0,1, 0,6,0,0,0));
        step("exit_5",         mk(0,0,1, 0,5,0,0,0));
        step("open_at_5",      mk(1,0,0, 1,5,0,0,0));

        // Asynchronous reset while the gate is open.
        @(negedge clk);
        reset = 1'b1;
        bus.entry_req = 1'b0;
        #1;
        check_now("async_reset_now", mk(0,0,0, 0,0,0,0,0));
        @(negedge clk);
        check_now("async_reset_held", mk(0,0,0, 0,0,0,0,0));
        reset = 1'b0;

        // Request held with no car: gate open exactly TIMEOUT cycles.
        gate_cycles = 0;
        tmo_pulses  = 0;
        for (int i = 1; i <= 1003; i++) begin
            step("timeout_run", mk(1,0,0, (i <= 1000), 0, 0, (i == 1001), 0));
            if (bus.gate_open === 1'b1) gate_cycles++;
            if (bus.timeout === 1'b1)   tmo_pulses++;
        end
        check_int("timeout_gate_cycles", gate_cycles, 1000);
        check_int("timeout_pulses", tmo_pulses, 1);
        step("timeout_release", mk(0,0,0, 0,0,0,0,0));
        step("timeout_rereq",   mk(1,0,0, 1,0,0,0,0));
        step("timeout_enter",   mk(1,1,0, 0,1,0,0,0));
        step("timeout_idle",    mk(0,0,0, 0,1,0,0,0));

        // Enter coincident with the final open cycle beats the timeout.
        step("race_open", mk(1,0,0, 1,1,0,0,0));
        for (int i = 2; i <= 1000; i++) begin
            step("race_wait", mk(1,0,0, 1,1,0,0,0));
        end
        step("race_enter", mk(1,1,0, 0,2,0,0,0));
        step("race_after", mk(1,0,0, 0,2,0,0,0));
        step("race_idle",  mk(0,0,0, 0,2,0,0,0));

        check_int("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
